// File: rtl/mem_cmd_pkg.sv
// Shared definitions for the memory command queue: default bus widths, the
// issue FSM state type and the packed command record.
// No ports (package).
package mem_cmd_pkg;

    localparam int unsigned MEM_ADDR_W = 5;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StResp
    } mem_cmd_state_e;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Width of a flattened {write, addr, wdata} command for arbitrary widths.
    function automatic int unsigned cmd_width(input int unsigned addr_w,
                                              input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/mem_cmd_queue_if.sv
// Bundle of the command, response and memory-side signals of mem_cmd_queue.
//   slave  : seen by the queue (accepts req, drives rsp/mem/fifo_count)
//   master : seen by the surrounding system (drives req, rsp_ready, mem_rdata)
interface mem_cmd_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = mem_cmd_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W = mem_cmd_pkg::MEM_DATA_W
);

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata,
               fifo_count
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata,
               fifo_count
    );

endinterface

// File: rtl/mem_cmd_fifo.sv
// Synchronous FIFO holding flattened commands; head is visible combinationally.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write an entry (ignored when full)
//   pop, pop_data       remove the head entry (ignored when empty); pop_data = head
//   full, empty, count  occupancy status
module mem_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = storage[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mem_cmd_queue.sv
// Queues read/write commands and issues them one at a time to a simple
// synchronous memory; read data is returned on a valid/ready response port.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         mem_cmd_queue_if.slave: req_* command input, rsp_* read
//               response, mem_* memory strobes/address/data, fifo_count
module mem_cmd_queue
    import mem_cmd_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_cmd_queue_if.slave bus
);

    localparam int unsigned CMD_W = cmd_width(ADDR_W, DATA_W);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    mem_cmd_state_e    state_q, state_d;
    logic              pop;
    logic [CMD_W-1:0]  push_data, head;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    assign push_data                           = {bus.req_write, bus.req_addr, bus.req_wdata};
    assign {head_write, head_addr, head_wdata} = head;

    mem_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.req_valid && !fifo_full),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            StIdle: begin
                // Strobes are registered here so they are high for exactly the ISSUE cycle.
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_wdata;
                    mem_read_d  = !head_write;
                    mem_write_d = head_write;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                state_d = mem_read_q ? StCapture : StIdle;
            end
            StCapture: begin
                // Memory returns data the cycle after it sampled mem_read.
                rsp_rdata_d = bus.mem_rdata;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready  = !fifo_full;
    assign bus.fifo_count = fifo_count;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_mem_cmd_queue.sv
// Scoreboard bench for mem_cmd_queue: accepted commands feed an in-order
// reference (expected memory ops and expected read data from a shadow memory);
// a negedge monitor compares every strobe, response and occupancy value.
module tb_mem_cmd_queue;
    import mem_cmd_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_cmd_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    mem_cmd_t   exp_ops[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] rsp_log[$];
    logic [7:0] ref_mem  [32];
    logic [7:0] phys_mem [32];
    int         pushed = 0;
    int         issued = 0;
    int         rsp_mode = 1;   // 0 random, 1 hold low, 2 hold high
    logic       prev_pend = 1'b0;
    logic [7:0] prev_data = '0;
    mem_cmd_t   mon_cmd;
    mem_cmd_t   mon_op;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Memory: writes on the strobe edge, read data one cycle after mem_read.
    always @(posedge clk) begin
        if (bus.mem_write) phys_mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  bus.mem_rdata <= phys_mem[bus.mem_addr];
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.rsp_ready = (rsp_mode == 0) ? ($urandom_range(0, 3) != 0) : (rsp_mode == 2);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_ops.delete();
            exp_rsp.delete();
            pushed    = 0;
            issued    = 0;
            prev_pend = 1'b0;
            ref_mem   = phys_mem;
        end else begin
            check("strobe_overlap", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
            if (bus.mem_read || bus.mem_write) begin
                issued++;
                if (exp_ops.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    mon_op = exp_ops.pop_front();
                    check("op_kind", {31'd0, bus.mem_write}, {31'd0, mon_op.write});
                    check("op_addr", {27'd0, bus.mem_addr}, {27'd0, mon_op.addr});
                    if (mon_op.write)
                        check("op_wdata", {24'd0, bus.mem_wdata}, {24'd0, mon_op.wdata});
                end
            end
            check("fifo_count", {29'd0, bus.fifo_count}, 32'(pushed - issued));
            check("req_ready", {31'd0, bus.req_ready}, {31'd0, (pushed - issued) != DEPTH});
            if (prev_pend) begin
                check("rsp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
                check("rsp_hold_data", {24'd0, bus.rsp_rdata}, {24'd0, prev_data});
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_log.push_back(bus.rsp_rdata);
                if (exp_rsp.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
                else check("rsp_data", {24'd0, bus.rsp_rdata}, {24'd0, exp_rsp.pop_front()});
            end
            prev_pend = bus.rsp_valid && !bus.rsp_ready;
            prev_data = bus.rsp_rdata;
            if (bus.req_valid && bus.req_ready) begin
                pushed++;
                mon_cmd.write = bus.req_write;
                mon_cmd.addr  = bus.req_addr;
                mon_cmd.wdata = bus.req_wdata;
                exp_ops.push_back(mon_cmd);
                if (mon_cmd.write) ref_mem[mon_cmd.addr] = mon_cmd.wdata;
                else exp_rsp.push_back(ref_mem[mon_cmd.addr]);
            end
        end
    end

    // Call just after a posedge; returns just after the edge that accepted it.
    task automatic push_cmd(input logic wr, input logic [4:0] a, input logic [7:0] d);
        logic acc;
        int   n;
        n             = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        do begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        int n;
        int quiet;
        n        = 0;
        quiet    = 0;
        rsp_mode = 2;
        bus.req_valid = 1'b0;
        while (quiet < 2 && n < 400) begin
            @(negedge clk);
            n++;
            if (exp_ops.size() == 0 && exp_rsp.size() == 0 && bus.fifo_count == 0 &&
                !bus.rsp_valid && !bus.mem_read && !bus.mem_write)
                quiet++;
            else
                quiet = 0;
        end
        check("drain_timeout", {31'd0, quiet < 2}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_valid(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 50);
        check(tag, {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_read"},   {31'd0, bus.mem_read},   32'd0);
        check({tag, "_mem_write"},  {31'd0, bus.mem_write},  32'd0);
        check({tag, "_rsp_valid"},  {31'd0, bus.rsp_valid},  32'd0);
        check({tag, "_mem_addr"},   {27'd0, bus.mem_addr},   32'd0);
        check({tag, "_mem_wdata"},  {24'd0, bus.mem_wdata},  32'd0);
        check({tag, "_rsp_rdata"},  {24'd0, bus.rsp_rdata},  32'd0);
        check({tag, "_fifo_count"}, {29'd0, bus.fifo_count}, 32'd0);
        check({tag, "_req_ready"},  {31'd0, bus.req_ready},  32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) phys_mem[i] = 8'(i * 7 + 3);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write 0xA5 to 3 then read 3, with exact strobe/response cycles.
        wait_idle();
        push_cmd(1'b1, 5'd3, 8'hA5);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("wr_n0_strobe", {31'd0, bus.mem_write}, 32'd0);
        @(negedge clk);
        check("wr_n1_strobe", {31'd0, bus.mem_write}, 32'd1);
        check("wr_n1_addr", {27'd0, bus.mem_addr}, 32'd3);
        check("wr_n1_data", {24'd0, bus.mem_wdata}, 32'hA5);
        @(negedge clk);
        check("wr_n2_strobe", {31'd0, bus.mem_write}, 32'd0);
        @(posedge clk);
        #1;
        push_cmd(1'b0, 5'd3, 8'h00);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rd_n0_strobe", {31'd0, bus.mem_read}, 32'd0);
        @(negedge clk);
        check("rd_n1_strobe", {31'd0, bus.mem_read}, 32'd1);
        check("rd_n1_addr", {27'd0, bus.mem_addr}, 32'd3);
        @(negedge clk);
        check("rd_n2_strobe", {31'd0, bus.mem_read}, 32'd0);
        check("rd_n2_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        check("rd_n3_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("rd_n3_data", {24'd0, bus.rsp_rdata}, 32'hA5);

        // Stall in RESP and fill the FIFO; the fifth command must wait.
        wait_idle();
        rsp_mode = 1;
        push_cmd(1'b0, 5'd9, 8'h00);
        bus.req_valid = 1'b0;
        wait_rsp_valid("stall_rsp_valid");
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 5'(16 + i), 8'(8'h40 + i));
        bus.req_write = 1'b1;
        bus.req_addr  = 5'd20;
        bus.req_wdata = 8'h44;
        repeat (3) begin
            @(negedge clk);
            check("full_count", {29'd0, bus.fifo_count}, 32'd4);
            check("full_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        rsp_mode = 2;
        @(posedge clk);
        #1;
        push_cmd(1'b1, 5'd20, 8'h44);
        bus.req_valid = 1'b0;

        // Read 31 held for 6 cycles, released by a single rsp_ready edge.
        wait_idle();
        push_cmd(1'b1, 5'd31, 8'hC3);
        rsp_mode = 1;
        push_cmd(1'b0, 5'd31, 8'h00);
        bus.req_valid = 1'b0;
        wait_rsp_valid("hold_rsp_valid");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("hold_data", {24'd0, bus.rsp_rdata}, 32'hC3);
        end
        @(posedge clk);
        #1 rsp_mode = 2;
        @(negedge clk);
        check("hold_valid_at_ready", {31'd0, bus.rsp_valid}, 32'd1);
        @(posedge clk);
        #1 rsp_mode = 1;
        @(negedge clk);
        check("hold_valid_dropped", {31'd0, bus.rsp_valid}, 32'd0);

        // Write 0..7 with 0x10..0x17, read back in order with random backpressure.
        wait_idle();
        rsp_log.delete();
        rsp_mode = 0;
        for (int i = 0; i < 8; i++) push_cmd(1'b1, 5'(i), 8'(8'h10 + i));
        for (int i = 0; i < 8; i++) push_cmd(1'b0, 5'(i), 8'($urandom));
        bus.req_valid = 1'b0;
        wait_idle();
        check("seq_rsp_count", 32'(rsp_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < rsp_log.size(); i++)
            check("seq_rsp_value", {24'd0, rsp_log[i]}, 32'(8'h10 + i));

        // Random traffic.
        rsp_mode = 0;
        for (int i = 0; i < 150; i++) begin
            push_cmd(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
            bus.req_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();

        // Reset while a read is in CAPTURE with two writes queued.
        rsp_mode = 1;
        push_cmd(1'b0, 5'd5, 8'h00);
        push_cmd(1'b1, 5'd6, 8'h66);
        push_cmd(1'b1, 5'd7, 8'h77);
        bus.req_valid = 1'b0;
        check("pre_reset_count", {29'd0, bus.fifo_count}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post_reset_no_strobe", {31'd0, bus.mem_read | bus.mem_write}, 32'd0);
            check("post_reset_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end

        // Still functional after reset.
        @(posedge clk);
        #1;
        rsp_log.delete();
        rsp_mode = 2;
        push_cmd(1'b1, 5'd6, 8'h99);
        push_cmd(1'b0, 5'd6, 8'h00);
        bus.req_valid = 1'b0;
        wait_idle();
        check("after_reset_rsp_count", 32'(rsp_log.size()), 32'd1);
        if (rsp_log.size() > 0) check("after_reset_rsp", {24'd0, rsp_log[0]}, 32'h99);
        check("end_ops_empty", 32'(exp_ops.size()), 32'd0);
        check("end_rsp_empty", 32'(exp_rsp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_cmd_queue.md
MEM_CMD_QUEUE -- requirements
Module: mem_cmd_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  4  command FIFO entries, power of two, minimum 2.
  ADDR_W  5  memory address width.
  DATA_W  8  memory data width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on posedge.
  rst_n  in  1  asynchronous, active-low reset.
  req_valid  in  1  upstream command valid.
  req_ready  out  1  queue can accept a command.
  req_write  in  1  1 = write, 0 = read.
  req_addr  in  ADDR_W  command address.
  req_wdata  in  DATA_W  write data; ignored for reads.
  rsp_valid  out  1  read data valid.
  rsp_ready  in  1  downstream accepts read data.
  rsp_rdata  out  DATA_W  read data.
  mem_read  out  1  memory read strobe.
  mem_write  out  1  memory write strobe.
  mem_addr  out  ADDR_W  memory address.
  mem_wdata  out  DATA_W  data to memory.
  mem_rdata  in  DATA_W  data from memory; valid the cycle after the edge that sampled mem_read.
  fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 A command SHALL be pushed on any posedge with req_valid && req_ready; req_ready SHALL equal (fifo_count != DEPTH), combinational from the occupancy only.
REQ-005 The FIFO SHALL preserve order; pointers SHALL wrap modulo DEPTH; push and pop on the same edge SHALL leave fifo_count unchanged.
REQ-006 The issue FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP.
REQ-007 IDLE: if FIFO non-empty, pop head, register mem_addr/mem_wdata and the matching strobe, go ISSUE; else stay.
REQ-008 ISSUE: exactly one of mem_read/mem_write SHALL be high for this single cycle; next state CAPTURE for reads, IDLE for writes.
REQ-009 CAPTURE: strobes low; on the edge ending this cycle rsp_rdata SHALL load mem_rdata and rsp_valid SHALL rise; go RESP.
REQ-010 RESP: rsp_valid and rsp_rdata SHALL hold stable until the edge with rsp_ready high, then rsp_valid falls and the FSM goes IDLE.
REQ-011 mem_read and mem_write SHALL never be high together, and SHALL be high only in ISSUE.
REQ-012 Latency: command pushed into an empty FIFO at edge N SHALL strobe memory during cycle N+1..N+2; read data SHALL be visible with rsp_valid from edge N+3; write throughput one per 2 cycles.
REQ-013 Writes SHALL produce no response; pushes SHALL continue while the FSM is in CAPTURE or RESP.
REQ-014 mem_addr and mem_wdata SHALL hold their last issued value outside ISSUE.

Reset
REQ-015 rst_n low SHALL immediately clear FSM to IDLE, pointers and fifo_count to 0, and drive mem_read, mem_write, rsp_valid low, mem_addr, mem_wdata, rsp_rdata to 0; req_ready SHALL read 1.
REQ-016 Reset mid-operation SHALL discard queued and in-flight commands without any further strobe; no pending response survives reset.

Structure
REQ-017 Package mem_cmd_pkg SHALL hold ADDR_W/DATA_W defaults, the FSM state enum, and a packed command struct (write, addr, wdata).
REQ-018 Storage SHALL be a sub-module mem_cmd_fifo (push/pop/full/empty/count); FSM and memory-side registers live in mem_cmd_queue.

Verification
REQ-019 Write 0xA5 to addr 3, then read addr 3 -> one mem_write cycle with addr 3/data 0xA5, then rsp_valid with rsp_rdata 0xA5 at edge N+3 of the read push.
REQ-020 Push 5 commands back-to-back with FSM stalled in RESP (rsp_ready=0) -> req_ready low after fifo_count reaches 4, fifth held until a pop.
REQ-021 Read addr 31 with rsp_ready low for 6 cycles -> rsp_valid and rsp_rdata stable for all 6, drop one edge after rsp_ready.
REQ-022 Write addr 0..7 with data 0x10..0x17, read back in order -> responses 0x10..0x17, no strobe overlap, pointers wrap twice.
REQ-023 Assert rst_n low during CAPTURE with 2 entries queued -> all outputs reset immediately, no further mem strobes, fifo_count 0, req_ready 1.
